// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for a 5-stage core (IF/ID/EX/MEM/WB).
// Produces per-stage stall, bubble and flush controls for three cases:
//   - load-use hazards that forwarding cannot cover,
//   - data-memory wait states,
//   - taken-branch squashes.
// It also detects data-memory timeouts and keeps saturating stall/flush counters.
//
// State and counters are registered. The control outputs are combinational
// from the current state and inputs, so a stall applies in the same cycle the
// hazard is seen. While rst is high, every control output is held at 0.
//
// Handshake with data memory: i_mem_req marks an access outstanding in MEM.
// The access completes in the cycle where i_mem_req and i_mem_ready are both 1.
// i_mem_ready with no request is ignored in RUN.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_ra_addr_if_id,
  input  logic [4:0]       i_rb_addr_if_id,
  input  logic             i_ra_used_if_id,
  input  logic             i_rb_used_if_id,
  input  logic [4:0]       i_rd_addr_id_ex,
  input  logic             i_is_load_id_ex,
  input  logic             i_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_stall_pc,
  output logic             o_stall_if_id,
  output logic             o_stall_id_ex,
  output logic             o_stall_ex_mem,
  output logic             o_bubble_id_ex,
  output logic             o_bubble_mem_wb,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_mem_fault,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  localparam logic [15:0]      TIMEOUT = 16'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [15:0]      r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic w_lu;
  logic w_mw;
  logic w_freeze;
  logic w_dispatch;
  logic w_flush_evt;

  logic w_stall_pc;
  logic w_stall_if_id;
  logic w_stall_id_ex;
  logic w_stall_ex_mem;
  logic w_bubble_id_ex;
  logic w_bubble_mem_wb;
  logic w_flush_if_id;
  logic w_flush_id_ex;
  logic w_mem_fault;

  // Hazard terms from the current inputs.
  always_comb begin
    w_lu = i_is_load_id_ex && (i_rd_addr_id_ex != 5'd0) &&
           ((i_ra_used_if_id && (i_rd_addr_id_ex == i_ra_addr_if_id)) ||
            (i_rb_used_if_id && (i_rd_addr_id_ex == i_rb_addr_if_id)));
    w_mw = i_mem_req && !i_mem_ready;
  end

  // Control decode.
  // Freeze: a new wait in RUN, or an unfinished wait in MEM_WAIT.
  // Dispatch: a RUN cycle with no wait, or the ready cycle that ends a wait
  // (a pending branch or load-use hazard is acted on in that same cycle).
  always_comb begin
    w_freeze        = 1'b0;
    w_dispatch      = 1'b0;
    w_flush_evt     = 1'b0;
    w_stall_pc      = 1'b0;
    w_stall_if_id   = 1'b0;
    w_stall_id_ex   = 1'b0;
    w_stall_ex_mem  = 1'b0;
    w_bubble_id_ex  = 1'b0;
    w_bubble_mem_wb = 1'b0;
    w_flush_if_id   = 1'b0;
    w_flush_id_ex   = 1'b0;
    w_mem_fault     = 1'b0;
    if (!rst) begin
      w_freeze   = ((r_state == ST_RUN) && w_mw) ||
                   ((r_state == ST_MEM_WAIT) && !i_mem_ready);
      w_dispatch = ((r_state == ST_RUN) && !w_mw) ||
                   ((r_state == ST_MEM_WAIT) && i_mem_ready);
      if (r_state == ST_FAULT) begin
        w_mem_fault     = 1'b1;
        w_flush_if_id   = 1'b1;
        w_flush_id_ex   = 1'b1;
        w_bubble_mem_wb = 1'b1;
      end else if (w_freeze) begin
        w_stall_pc      = 1'b1;
        w_stall_if_id   = 1'b1;
        w_stall_id_ex   = 1'b1;
        w_stall_ex_mem  = 1'b1;
        w_bubble_mem_wb = 1'b1;
      end else if (w_dispatch && i_branch_taken) begin
        // A load-use hazard in this cycle is squashed along with the branch shadow.
        w_flush_evt   = 1'b1;
        w_flush_if_id = 1'b1;
        w_flush_id_ex = 1'b1;
      end else if (w_dispatch && w_lu) begin
        w_stall_pc     = 1'b1;
        w_stall_if_id  = 1'b1;
        w_bubble_id_ex = 1'b1;
      end
    end
  end

  // Sequencer state and wait-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 16'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mw) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= 16'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (i_mem_ready) begin
            r_state <= ST_RUN;
          end else if (r_wait_cnt == TIMEOUT) begin
            r_state <= ST_FAULT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        ST_FAULT: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall_pc && (r_stall_cycles != CNT_MAX)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_flush_evt && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign o_stall_pc      = w_stall_pc;
  assign o_stall_if_id   = w_stall_if_id;
  assign o_stall_id_ex   = w_stall_id_ex;
  assign o_stall_ex_mem  = w_stall_ex_mem;
  assign o_bubble_id_ex  = w_bubble_id_ex;
  assign o_bubble_mem_wb = w_bubble_mem_wb;
  assign o_flush_if_id   = w_flush_if_id;
  assign o_flush_id_ex   = w_flush_id_ex;
  assign o_mem_fault     = w_mem_fault;
  assign o_stall_cycles  = r_stall_cycles;
  assign o_flush_count   = r_flush_count;
  assign o_state         = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed tests for pipe_ctrl.
// Inputs change on the falling edge. The combinational controls are sampled
// 1 ns later, which is well away from the rising edge.
// Controls are packed as
// {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_id_ex,
//  bubble_mem_wb, flush_if_id, flush_id_ex, mem_fault}.
module tb_pipe_ctrl;

  localparam int TMO = 8;
  localparam int CW  = 32;

  localparam logic [8:0] C_NONE   = 9'b000000000;
  localparam logic [8:0] C_LU     = 9'b110010000;
  localparam logic [8:0] C_FREEZE = 9'b111101000;
  localparam logic [8:0] C_FLUSH  = 9'b000000110;
  localparam logic [8:0] C_FAULT  = 9'b000001111;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FLT  = 2'd2;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]    ra_addr, rb_addr, rd_addr;
  logic          ra_used, rb_used, is_load, branch_taken, mem_req, mem_ready;
  logic          stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic          bubble_id_ex, bubble_mem_wb, flush_if_id, flush_id_ex, mem_fault;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [1:0]    state;
  logic [8:0]    ctl;

  int n_pass  = 0;
  int n_total = 0;

  assign ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_id_ex,
                bubble_mem_wb, flush_if_id, flush_id_ex, mem_fault};

  pipe_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_ra_addr_if_id(ra_addr), .i_rb_addr_if_id(rb_addr),
    .i_ra_used_if_id(ra_used), .i_rb_used_if_id(rb_used),
    .i_rd_addr_id_ex(rd_addr), .i_is_load_id_ex(is_load),
    .i_branch_taken(branch_taken), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_stall_pc(stall_pc), .o_stall_if_id(stall_if_id),
    .o_stall_id_ex(stall_id_ex), .o_stall_ex_mem(stall_ex_mem),
    .o_bubble_id_ex(bubble_id_ex), .o_bubble_mem_wb(bubble_mem_wb),
    .o_flush_if_id(flush_if_id), .o_flush_id_ex(flush_id_ex),
    .o_mem_fault(mem_fault), .o_stall_cycles(stall_cycles),
    .o_flush_count(flush_count), .o_state(state)
  );

  // Driver tasks
  task automatic drive_idle();
    ra_addr = 5'd0; rb_addr = 5'd0; rd_addr = 5'd0;
    ra_used = 1'b0; rb_used = 1'b0; is_load = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic drive_lu(input logic [4:0] rd, input logic [4:0] ra, input logic rau,
                          input logic [4:0] rb, input logic rbu);
    is_load = 1'b1; rd_addr = rd; ra_addr = ra; ra_used = rau; rb_addr = rb; rb_used = rbu;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
    drive_lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL reset_ctl got %b exp %b", ctl, C_NONE); else n_pass++;
    n_total++;
    if (state !== S_RUN) $display("FAIL reset_state got %0d exp %0d", state, S_RUN); else n_pass++;
    n_total++;
    if (stall_cycles !== '0 || flush_count !== '0)
      $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cycles, flush_count);
    else n_pass++;
    drive_idle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    apply_reset();
    drive_lu(5'd3, 5'd3, 1'b1, 5'd7, 1'b1);
    #1;
    n_total++;
    if (ctl !== C_LU) $display("FAIL lu_ra got %b exp %b", ctl, C_LU); else n_pass++;
    next_cycle();
    drive_idle();
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL lu_one_cycle got %b exp %b", ctl, C_NONE); else n_pass++;
    n_total++;
    if (stall_cycles !== 32'd1) $display("FAIL lu_stall_cnt got %0d exp 1", stall_cycles); else n_pass++;
    drive_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL lu_r0 got %b exp %b", ctl, C_NONE); else n_pass++;
    drive_lu(5'd3, 5'd3, 1'b0, 5'd4, 1'b1);
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL lu_ra_unused got %b exp %b", ctl, C_NONE); else n_pass++;
    drive_lu(5'd9, 5'd1, 1'b1, 5'd9, 1'b1);
    #1;
    n_total++;
    if (ctl !== C_LU) $display("FAIL lu_rb got %b exp %b", ctl, C_LU); else n_pass++;
    next_cycle();
    drive_idle();
    #1;
    n_total++;
    if (stall_cycles !== 32'd2) $display("FAIL lu_stall_cnt2 got %0d exp 2", stall_cycles); else n_pass++;
  endtask

  task automatic test_branch_over_lu();
    apply_reset();
    drive_lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    branch_taken = 1'b1;
    #1;
    n_total++;
    if (ctl !== C_FLUSH) $display("FAIL br_lu got %b exp %b", ctl, C_FLUSH); else n_pass++;
    next_cycle();
    drive_idle();
    #1;
    n_total++;
    if (flush_count !== 32'd1 || stall_cycles !== 32'd0)
      $display("FAIL br_lu_cnt got %0d/%0d exp 1/0", flush_count, stall_cycles);
    else n_pass++;
  endtask

  task automatic test_mem_wait();
    apply_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if (ctl !== C_FREEZE) $display("FAIL mw_freeze%0d got %b exp %b", i, ctl, C_FREEZE); else n_pass++;
      next_cycle();
    end
    mem_ready = 1'b1;
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL mw_release got %b exp %b", ctl, C_NONE); else n_pass++;
    next_cycle();
    drive_idle();
    #1;
    n_total++;
    if (stall_cycles !== 32'd4) $display("FAIL mw_stall_cnt got %0d exp 4", stall_cycles); else n_pass++;
    n_total++;
    if (state !== S_RUN) $display("FAIL mw_state got %0d exp %0d", state, S_RUN); else n_pass++;
  endtask

  task automatic test_timeout();
    apply_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < TMO + 1; i++) begin
      #1;
      n_total++;
      if (ctl !== C_FREEZE) $display("FAIL to_freeze%0d got %b exp %b", i, ctl, C_FREEZE); else n_pass++;
      next_cycle();
    end
    mem_req = 1'b0;
    #1;
    n_total++;
    if (ctl !== C_FAULT) $display("FAIL to_fault got %b exp %b", ctl, C_FAULT); else n_pass++;
    n_total++;
    if (state !== S_FLT) $display("FAIL to_state got %0d exp %0d", state, S_FLT); else n_pass++;
    next_cycle();
    #1;
    n_total++;
    if (ctl !== C_NONE || state !== S_RUN)
      $display("FAIL to_after got %b/%0d exp %b/%0d", ctl, state, C_NONE, S_RUN);
    else n_pass++;
    n_total++;
    if (stall_cycles !== 32'd9 || flush_count !== 32'd0)
      $display("FAIL to_cnt got %0d/%0d exp 9/0", stall_cycles, flush_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int frz;
    apply_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    mem_ready = 1'b1;
    next_cycle();
    // A second access starts right after the ready cycle and never completes.
    // Its wait count must restart at 1, so it freezes for TMO+1 cycles
    // before the fault cycle.
    mem_ready = 1'b0;
    frz = 0;
    for (int i = 0; i < TMO + 4; i++) begin
      #1;
      if (ctl === C_FAULT) break;
      if (ctl === C_FREEZE) frz++;
      next_cycle();
    end
    n_total++;
    if (ctl !== C_FAULT) $display("FAIL b2b_fault got %b exp %b", ctl, C_FAULT); else n_pass++;
    n_total++;
    if (frz != TMO + 1) $display("FAIL b2b_freeze_len got %0d exp %0d", frz, TMO + 1); else n_pass++;
    drive_idle();
    next_cycle();
    #1;
    n_total++;
    if (stall_cycles !== 32'd12) $display("FAIL b2b_stall_cnt got %0d exp 12", stall_cycles); else n_pass++;
  endtask

  task automatic test_branch_in_wait();
    apply_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    next_cycle();
    branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++;
      if (ctl !== C_FREEZE) $display("FAIL bw_freeze%0d got %b exp %b", i, ctl, C_FREEZE); else n_pass++;
      next_cycle();
    end
    mem_ready = 1'b1;
    #1;
    n_total++;
    if (ctl !== C_FLUSH) $display("FAIL bw_ready_flush got %b exp %b", ctl, C_FLUSH); else n_pass++;
    next_cycle();
    drive_idle();
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL bw_after got %b exp %b", ctl, C_NONE); else n_pass++;
    n_total++;
    if (flush_count !== 32'd1 || stall_cycles !== 32'd3)
      $display("FAIL bw_cnt got %0d/%0d exp 1/3", flush_count, stall_cycles);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    #1;
    n_total++;
    if (state !== S_WAIT) $display("FAIL rw_pre_state got %0d exp %0d", state, S_WAIT); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (ctl !== C_NONE) $display("FAIL rw_ctl got %b exp %b", ctl, C_NONE); else n_pass++;
    n_total++;
    if (state !== S_RUN || stall_cycles !== '0 || flush_count !== '0)
      $display("FAIL rw_regs got %0d/%0d/%0d exp 0/0/0", state, stall_cycles, flush_count);
    else n_pass++;
    next_cycle();
    rst = 1'b0;
    drive_idle();
    #1;
    n_total++;
    if (ctl !== C_NONE || state !== S_RUN)
      $display("FAIL rw_release got %b/%0d exp %b/%0d", ctl, state, C_NONE, S_RUN);
    else n_pass++;
    mem_req = 1'b1;
    #1;
    n_total++;
    if (ctl !== C_FREEZE) $display("FAIL rw_new_access got %b exp %b", ctl, C_FREEZE); else n_pass++;
    next_cycle();
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_load_use();
    test_branch_over_lu();
    test_mem_wait();
    test_timeout();
    test_back_to_back();
    test_branch_in_wait();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
